bcd_conv_ctrl: RTL and testbench
================================

BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

Interface
REQ-001 SHALL provide parameter IN_W, default 7, binary input width; legal range 1..9, so the result fits three BCD digits.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port in_valid  input  1  in_bin holds a value to convert.
REQ-005 SHALL provide port in_ready  output  1  block accepts a new value this cycle.
REQ-006 SHALL provide port in_bin  input  IN_W  unsigned binary operand.
REQ-007 SHALL provide port out_valid  output  1  out_bcd holds a fresh result.
REQ-008 SHALL provide port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL provide port out_bcd  output  12  result: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-010 SHALL provide port busy  output  1  conversion in progress (state SHIFT).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready.
REQ-013 On accept, SHALL load in_bin into the shift register, clear the BCD accumulator, set the iteration counter to IN_W and go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL add 3 to every BCD digit >= 5, then shift {bcd, bin} left one bit and decrement the counter.
REQ-015 SHALL go from SHIFT to DONE after exactly IN_W shift cycles.
REQ-016 out_valid SHALL be 1 only in DONE; first out_valid cycle is IN_W+1 cycles after the accept cycle (8 for IN_W=7).
REQ-017 In DONE, SHALL hold out_bcd stable until out_valid && out_ready, then return to IDLE on the next edge.
REQ-018 out_ready with out_valid low SHALL have no effect; in_valid outside IDLE SHALL be ignored, not queued.
REQ-019 out_bcd SHALL keep the last result after the output handshake, until the next DONE.
REQ-020 Max throughput SHALL be one conversion per IN_W+2 cycles with out_ready tied high.
REQ-021 Digit arithmetic SHALL be 4-bit per digit; no digit exceeds 9 for any legal input.

Reset
REQ-022 When rst_n=0 at a clock edge, SHALL enter IDLE, clear the shift register, accumulator and counter.
REQ-023 After reset: in_ready=1, out_valid=0, busy=0, out_bcd=12'h000.
REQ-024 Reset during SHIFT or DONE SHALL abort; the partial or pending result is discarded and never presented.

Configuration
REQ-025 Macro BCD_LZ_BLANK_EN SHALL, when defined, add port out_blank  output  3  per-digit blank mask, [2] hundreds, [1] tens, [0] units.
REQ-026 With BCD_LZ_BLANK_EN: out_blank[2]=1 iff hundreds=0; out_blank[1]=1 iff hundreds=0 and tens=0; out_blank[0] always 0. The mask is registered with out_bcd, and its reset value is 3'b110.
REQ-027 Without BCD_LZ_BLANK_EN, out_blank SHALL not exist and no blanking logic SHALL be synthesised.

Structure
REQ-028 Shared package SHALL hold the FSM state enum, the BCD digit width constant (4) and the digit-count constant (3).
REQ-029 SHALL instantiate one sub-module bcd_digit_adj: a 4-bit combinational add-3-if->=5 cell, used once per digit. All sequencing stays in bcd_conv_ctrl.

Verification
REQ-030 Drive in_bin=0, out_ready=1 -> out_bcd=12'h000 with out_valid high exactly 8 cycles after accept.
REQ-031 Drive in_bin=127 -> out_bcd=12'h127; drive in_bin=99 -> out_bcd=12'h099.
REQ-032 Drive in_bin=64, hold out_ready=0 for 5 cycles in DONE -> out_bcd=12'h064 stable and in_ready=0 throughout; second in_valid pulse in that window is not accepted.
REQ-033 Pull rst_n low on the 3rd SHIFT cycle -> next cycle IDLE, out_valid=0, out_bcd=12'h000; the following conversion of 45 -> 12'h045.
REQ-034 Sweep all inputs 0..127 back-to-back with out_ready=1 -> every result matches the decimal reference, and there is one accept every 9 cycles.
REQ-035 With BCD_LZ_BLANK_EN: 5 -> out_blank=3'b110; 42 -> 3'b100; 100 -> 3'b000.

Source files
------------

// File: rtl/bcd_conv_ctrl_pkg.sv
// Shared definitions for the binary-to-BCD conversion controller:
// FSM state encoding, BCD digit geometry and the leading-zero mask helper.
package bcd_conv_ctrl_pkg;

    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = 3;
    localparam int BCD_W    = DIGIT_W * N_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Blank mask for a 3-digit result: hundreds blank when zero, tens blank
    // only when hundreds is also zero, units never blank.
    function automatic logic [N_DIGITS-1:0] lz_blank_mask(input logic [BCD_W-1:0] bcd);
        logic hund_zero;
        logic tens_zero;
        hund_zero = (bcd[2*DIGIT_W +: DIGIT_W] == '0);
        tens_zero = (bcd[1*DIGIT_W +: DIGIT_W] == '0);
        return {hund_zero, hund_zero & tens_zero, 1'b0};
    endfunction

endpackage

// File: rtl/bcd_conv_ctrl_digit_adj.sv
// Single BCD digit correction cell for the shift-and-add-3 conversion:
// a digit of 5 or more gets 3 added so the following left shift carries
// correctly into the next decade.
module bcd_digit_adj
    import bcd_conv_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Add-3 correction, purely combinational.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(5)) begin
            digit_out = digit_in + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle,
// with valid/ready handshakes on both sides.
//
// Optional build macro: BCD_LZ_BLANK_EN adds out_blank, a registered
// leading-zero blank mask ([2] hundreds, [1] tens, [0] units).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for in_valid; in_ready high
// ST_SHIFT | one add-3/shift step per cycle, IN_W steps total; busy high
// ST_DONE  | result held on out_bcd with out_valid until out_ready
module bcd_conv_ctrl
    import bcd_conv_ctrl_pkg::*;
#(
    parameter int IN_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BCD_W-1:0]  out_bcd,
    output logic              busy
`ifdef BCD_LZ_BLANK_EN
    ,
    output logic [N_DIGITS-1:0] out_blank
`endif
);

    localparam int CNT_W = $clog2(IN_W + 1);

    state_t                  state;
    logic [IN_W-1:0]         bin_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [BCD_W-1:0]        adj;
    logic [BCD_W+IN_W-1:0]   shifted;
    logic [BCD_W-1:0]        next_bcd;
    logic [IN_W-1:0]         next_bin;
    logic                    last_step;

    // One correction cell per decade of the accumulator.
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_q[d*DIGIT_W +: DIGIT_W]),
            .digit_out (adj[d*DIGIT_W +: DIGIT_W])
        );
    end

    // Shift the corrected accumulator and the remaining operand bits as one
    // word; the top bit falls off (it is always zero for legal widths).
    always_comb begin
        shifted   = {adj, bin_q} << 1;
        next_bcd  = shifted[BCD_W+IN_W-1:IN_W];
        next_bin  = shifted[IN_W-1:0];
        last_step = (cnt_q == CNT_W'(1));
    end

    // Controller FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            out_bcd   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            out_blank <= 3'b110;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_q    <= in_bin;
                        bcd_q    <= '0;
                        cnt_q    <= CNT_W'(IN_W);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bin_q <= next_bin;
                    bcd_q <= next_bcd;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_step) begin
                        out_bcd   <= next_bcd;
`ifdef BCD_LZ_BLANK_EN
                        out_blank <= lz_blank_mask(next_bcd);
`endif
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Self-checking bench for bcd_conv_ctrl (IN_W = 7). Expected results come
// from plain decimal arithmetic on the operand.
module tb_bcd_conv_ctrl;

    localparam int IN_W    = 7;
    localparam int LAT_MAX = 40;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_bin;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       out_bcd;
    logic              busy;
`ifdef BCD_LZ_BLANK_EN
    logic [2:0]        out_blank;
`endif

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_acc = 0;
    int last_acc = 0;
    int n_sweep = 0;
    int gap_bad = 0;
    bit sweep_on = 0;

    bcd_conv_ctrl #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
`ifdef BCD_LZ_BLANK_EN
        ,
        .out_blank (out_blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept monitor: counts handshakes and measures spacing during the sweep.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            n_acc = n_acc + 1;
            if (sweep_on) begin
                if (n_sweep > 0 && (cyc - last_acc) != IN_W + 2) gap_bad = gap_bad + 1;
                n_sweep = n_sweep + 1;
            end
            last_acc = cyc;
        end
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] blank_of(input int v);
        logic [2:0] m;
        m[2] = (v < 100);
        m[1] = (v < 10);
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge while the DUT is idle; returns just after
    // the negedge of the first idle cycle following the output handshake.
    task automatic run_one(input int v, input int hold);
        int lat;
        int acc0;
        logic [11:0] e;
        e = to_bcd(v);
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_bin    = IN_W'(v);
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin   = IN_W'($urandom);
        acc0     = n_acc;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && lat <= IN_W) chk("busy_shift", busy, 1);
        end while (!out_valid && lat < LAT_MAX);
        chk("latency", lat, IN_W + 1);
        chk("result", out_bcd, e);
        chk("busy_done", busy, 0);
`ifdef BCD_LZ_BLANK_EN
        chk("blank", out_blank, blank_of(v));
`endif
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_bcd", out_bcd, e);
            chk("hold_in_ready", in_ready, 0);
            in_valid = (i == 2);
            in_bin   = IN_W'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_keep", out_bcd, e);
        chk("no_queue", n_acc, acc0);
    endtask

    initial begin
        int lat;
        bit saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_bcd", out_bcd, 12'h000);
`ifdef BCD_LZ_BLANK_EN
        chk("rst_blank", out_blank, 3'b110);
`endif

        // Directed values, including the boundary of the 7-bit range.
        run_one(0, 0);
        run_one(127, 0);
        run_one(99, 0);
        run_one(64, 5);
        run_one(5, 0);
        run_one(42, 1);
        run_one(100, 2);

        // Reset on the third SHIFT cycle aborts the conversion.
        in_valid  = 1'b1;
        in_bin    = IN_W'(113);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_bcd", out_bcd, 12'h000);
        chk("abort_busy_low", busy, 0);
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_never_valid", saw_valid, 0);
        run_one(45, 0);

        // Reset while a result is pending in DONE discards it.
        in_valid  = 1'b1;
        in_bin    = IN_W'(87);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < LAT_MAX);
        chk("done_pending", out_bcd, to_bcd(87));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("done_rst_valid", out_valid, 0);
        chk("done_rst_bcd", out_bcd, 12'h000);
        chk("done_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_rst_stays", out_valid, 0);

        // Full back-to-back sweep with out_ready held high.
        sweep_on = 1'b1;
        for (int v = 0; v < (1 << IN_W); v++) run_one(v, 0);
        sweep_on = 1'b0;
        chk("sweep_accepts", n_sweep, 1 << IN_W);
        chk("sweep_spacing", gap_bad, 0);

        // Random operands with random consumer back-pressure.
        repeat (24) run_one(int'($urandom_range(0, (1 << IN_W) - 1)), int'($urandom_range(0, 4)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
